// File: rtl/ball_engine.sv
// ============================================================================
// Module   : ball_engine
// Pong ball/score engine: ball motion, paddle/wall collisions, serve timing
// and two-digit BCD scoring. Optional macro SPEED_RAMP_EN speeds the ball up
// by 1 px/tick on every paddle hit, capped at DX_MAX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_engine #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int BALL_W      = 8,
    parameter int WALL_W      = 8,
    parameter int PADDLE_W    = 16,
    parameter int PADDLE_LEN  = 64,
    parameter int GOAL_MARGIN = 7,
    parameter int DX_INIT     = 2,
    parameter int DX_MAX      = 6,
    parameter int SERVE_TICKS = 60,
    parameter int WIN_SCORE   = 11,
    parameter int XW          = 10,
    parameter int YW          = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          start,
    input  logic [YW-1:0] paddle_l_y,
    input  logic [YW-1:0] paddle_r_y,
    input  logic [15:0]   rand_in,
    output logic [XW-1:0] ball_x,
    output logic [YW-1:0] ball_y,
    output logic          dir_x,
    output logic [7:0]    score_l,
    output logic [7:0]    score_r,
    output logic          point_l,
    output logic          point_r,
    output logic          in_play,
    output logic          game_over
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    typedef logic [XW:0] xe_t;
    typedef logic [YW:0] ye_t;

    localparam xe_t c_cx        = xe_t'((H_RES - BALL_W) / 2);
    localparam xe_t c_x_max     = xe_t'(H_RES - BALL_W);
    localparam xe_t c_bw_x      = xe_t'(BALL_W);
    localparam xe_t c_goal_lo   = xe_t'(GOAL_MARGIN);
    localparam xe_t c_goal_hi   = xe_t'(H_RES - 1 - GOAL_MARGIN);
    localparam xe_t c_pad_l     = xe_t'(PADDLE_W);
    localparam xe_t c_pad_r     = xe_t'(H_RES - 1 - PADDLE_W);
    localparam xe_t c_dx_init   = xe_t'(DX_INIT);
    localparam xe_t c_dx_max    = xe_t'(DX_MAX);
    localparam ye_t c_cy        = ye_t'((V_RES - BALL_W) / 2);
    localparam ye_t c_y_max     = ye_t'(V_RES - BALL_W);
    localparam ye_t c_bw_y      = ye_t'(BALL_W);
    localparam ye_t c_wall_top  = ye_t'(WALL_W);
    localparam ye_t c_wall_bot  = ye_t'(V_RES - 1 - WALL_W);
    localparam ye_t c_pad_len   = ye_t'(PADDLE_LEN);
    localparam logic [15:0] c_serve_ticks = 16'(SERVE_TICKS);
    localparam logic [7:0]  c_win_bcd     = 8'((WIN_SCORE / 10) * 16 + (WIN_SCORE % 10));
`ifdef SPEED_RAMP_EN
    localparam logic c_ramp_en = 1'b1;
`else
    localparam logic c_ramp_en = 1'b0;
`endif

    state_t          r_state, w_state_next;
    logic [XW-1:0]   r_ball_x;
    logic [YW-1:0]   r_ball_y;
    xe_t             r_dx;
    logic [2:0]      r_dy;
    logic            r_dir_x, r_dir_y;
    logic [7:0]      r_score_l, r_score_r;
    logic            r_point_l, r_point_r, r_last_l;
    logic [15:0]     r_cnt;

    xe_t             w_x_ext, w_x_sum, w_dx_hit;
    ye_t             w_y_ext, w_y_sum, w_dy_ext, w_pl_ext, w_pr_ext;
    logic [XW-1:0]   w_x_diff, w_x_next;
    logic [YW-1:0]   w_y_diff, w_y_next;
    logic [15:0]     w_cnt_inc;
    logic [2:0]      w_dy_rand;
    logic            w_goal_l, w_goal_r, w_ovl_l, w_ovl_r, w_hit_l, w_hit_r;
    logic            w_dir_x_new, w_dir_y_new, w_win, w_serve_entry, w_serve_dir, w_cnt_done;
    logic            w_unused_rand;

    function automatic logic [7:0] f_bcd_inc(input logic [7:0] s);
        if (s == 8'h99)
            return s;
        if (s[3:0] == 4'd9)
            return {s[7:4] + 4'd1, 4'd0};
        return {s[7:4], s[3:0] + 4'd1};
    endfunction

    assign w_unused_rand = ^rand_in[15:3];
    assign w_dy_rand     = {rand_in[2:1], 1'b1};

    assign w_x_ext  = {1'b0, r_ball_x};
    assign w_y_ext  = {1'b0, r_ball_y};
    assign w_dy_ext = {{(YW-2){1'b0}}, r_dy};
    assign w_pl_ext = {1'b0, paddle_l_y};
    assign w_pr_ext = {1'b0, paddle_r_y};

    assign w_goal_r = (w_x_ext <= c_goal_lo);
    assign w_goal_l = ((w_x_ext + c_bw_x) >= c_goal_hi);
    assign w_ovl_l  = ((w_y_ext + c_bw_y) > w_pl_ext) && (w_y_ext < (w_pl_ext + c_pad_len));
    assign w_ovl_r  = ((w_y_ext + c_bw_y) > w_pr_ext) && (w_y_ext < (w_pr_ext + c_pad_len));
    assign w_hit_l  = (w_x_ext < c_pad_l) && w_ovl_l;
    assign w_hit_r  = ((w_x_ext + c_bw_x) > c_pad_r) && w_ovl_r;

    assign w_x_sum  = w_x_ext + r_dx;
    assign w_x_diff = r_ball_x - r_dx[XW-1:0];
    assign w_y_sum  = w_y_ext + w_dy_ext;
    assign w_y_diff = r_ball_y - w_dy_ext[YW-1:0];

    assign w_dx_hit = !c_ramp_en ? r_dx :
                      (r_dx < c_dx_max) ? (r_dx + xe_t'(1)) : c_dx_max;

    assign w_cnt_inc     = r_cnt + 16'd1;
    assign w_cnt_done    = (w_cnt_inc == c_serve_ticks);
    assign w_win         = r_last_l ? (r_score_l == c_win_bcd) : (r_score_r == c_win_bcd);
    assign w_serve_entry = ((r_state == S_IDLE) && start) || ((r_state == S_POINT) && !w_win);
    // The serve heads toward whoever conceded; the opening serve goes right.
    assign w_serve_dir   = (r_state == S_POINT) && !r_last_l;

    // Direction updates take effect in the same tick as the move that uses them.
    always_comb begin
        w_dir_x_new = r_dir_x;
        w_dir_y_new = r_dir_y;
        w_x_next    = r_ball_x;
        w_y_next    = r_ball_y;
        if (w_hit_l)
            w_dir_x_new = 1'b0;
        else if (w_hit_r)
            w_dir_x_new = 1'b1;
        if (w_y_ext < c_wall_top)
            w_dir_y_new = 1'b0;
        else if ((w_y_ext + c_bw_y) > c_wall_bot)
            w_dir_y_new = 1'b1;
        if (w_dir_x_new)
            w_x_next = (w_x_ext < r_dx) ? '0 : w_x_diff;
        else
            w_x_next = (w_x_sum > c_x_max) ? c_x_max[XW-1:0] : w_x_sum[XW-1:0];
        if (w_dir_y_new)
            w_y_next = (w_y_ext < w_dy_ext) ? '0 : w_y_diff;
        else
            w_y_next = (w_y_sum > c_y_max) ? c_y_max[YW-1:0] : w_y_sum[YW-1:0];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SERVE;
            S_SERVE: if (tick && w_cnt_done) w_state_next = S_PLAY;
            S_PLAY:  if (tick && (w_goal_l || w_goal_r)) w_state_next = S_POINT;
            S_POINT: w_state_next = w_win ? S_OVER : S_SERVE;
            S_OVER:  if (start) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ball_x  <= c_cx[XW-1:0];
            r_ball_y  <= c_cy[YW-1:0];
            r_dx      <= c_dx_init;
            r_dy      <= 3'd1;
            r_dir_x   <= 1'b0;
            r_dir_y   <= 1'b0;
            r_score_l <= 8'h00;
            r_score_r <= 8'h00;
            r_point_l <= 1'b0;
            r_point_r <= 1'b0;
            r_last_l  <= 1'b0;
            r_cnt     <= 16'd0;
        end else begin
            r_point_l <= 1'b0;
            r_point_r <= 1'b0;
            if (w_serve_entry) begin
                r_ball_x <= c_cx[XW-1:0];
                r_ball_y <= c_cy[YW-1:0];
                r_dx     <= c_dx_init;
                r_dy     <= w_dy_rand;
                r_dir_y  <= rand_in[0];
                r_dir_x  <= w_serve_dir;
                r_cnt    <= 16'd0;
            end else if ((r_state == S_SERVE) && tick) begin
                r_cnt <= w_cnt_inc;
            end else if ((r_state == S_PLAY) && tick) begin
                if (w_goal_r) begin
                    r_score_r <= f_bcd_inc(r_score_r);
                    r_point_r <= 1'b1;
                    r_last_l  <= 1'b0;
                end else if (w_goal_l) begin
                    r_score_l <= f_bcd_inc(r_score_l);
                    r_point_l <= 1'b1;
                    r_last_l  <= 1'b1;
                end else begin
                    r_dir_x  <= w_dir_x_new;
                    r_dir_y  <= w_dir_y_new;
                    r_ball_x <= w_x_next;
                    r_ball_y <= w_y_next;
                    if (w_hit_l || w_hit_r) begin
                        r_dy <= w_dy_rand;
                        r_dx <= w_dx_hit;
                    end
                end
            end else if ((r_state == S_OVER) && start) begin
                r_score_l <= 8'h00;
                r_score_r <= 8'h00;
            end
        end
    end

    assign ball_x    = r_ball_x;
    assign ball_y    = r_ball_y;
    assign dir_x     = r_dir_x;
    assign score_l   = r_score_l;
    assign score_r   = r_score_r;
    assign point_l   = r_point_l;
    assign point_r   = r_point_r;
    assign in_play   = (r_state == S_PLAY);
    assign game_over = (r_state == S_OVER);

endmodule

`default_nettype wire

// File: tb/tb_ball_engine.sv
// ============================================================================
// Module   : tb_ball_engine
// Randomized self-checking bench for ball_engine against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ball_engine;

    localparam int CX = (640 - 8) / 2;
    localparam int CY = (480 - 8) / 2;
    localparam int M_IDLE  = 0;
    localparam int M_SERVE = 1;
    localparam int M_PLAY  = 2;
    localparam int M_POINT = 3;
    localparam int M_OVER  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  paddle_l_y = '0;
    logic [8:0]  paddle_r_y = '0;
    logic [15:0] rand_in = '0;
    logic [9:0]  ball_x;
    logic [8:0]  ball_y;
    logic        dir_x, point_l, point_r, in_play, game_over;
    logic [7:0]  score_l, score_r;

    always #5 clk = ~clk;

    ball_engine dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y), .rand_in(rand_in),
        .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x),
        .score_l(score_l), .score_r(score_r),
        .point_l(point_l), .point_r(point_r),
        .in_play(in_play), .game_over(game_over)
    );

    // Model state: plain integers, decimal scores, mode number.
    int m_mode = M_IDLE, m_x = 0, m_y = 0, m_dx = 0, m_dy = 0, m_sl = 0, m_sr = 0, m_cnt = 0;
    bit m_dirx = 0, m_diry = 0, m_pl = 0, m_pr = 0, m_last_l = 0, m_valid = 0;
    bit trk_l = 0, trk_r = 0, no_track = 0;
    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int to_bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    function automatic bit overlap(input int y, input int py);
        return (y + 8 > py) && (y < py + 64);
    endfunction

    function automatic int bump(input int s);
        return (s >= 99) ? 99 : s + 1;
    endfunction

    task automatic reroll();
        trk_l = ($urandom_range(0, 9) < 7);
        trk_r = ($urandom_range(0, 9) < 7);
    endtask

    task automatic serve(input bit dirx);
        m_x    = CX;
        m_y    = CY;
        m_dx   = 2;
        m_dy   = 2 * int'(rand_in[2:1]) + 1;
        m_diry = rand_in[0];
        m_dirx = dirx;
        m_cnt  = 0;
        m_mode = M_SERVE;
        reroll();
    endtask

    task automatic model_step();
        int odx, ody;
        bit hl, hr;
        if (reset) begin
            m_mode = M_IDLE; m_x = CX; m_y = CY; m_dx = 2; m_dy = 1;
            m_dirx = 0; m_diry = 0; m_sl = 0; m_sr = 0; m_pl = 0; m_pr = 0;
            m_last_l = 0; m_cnt = 0; m_valid = 1;
        end else begin
            m_pl = 0;
            m_pr = 0;
            case (m_mode)
                M_IDLE:  if (start) serve(1'b0);
                M_SERVE: if (tick) begin
                    m_cnt++;
                    if (m_cnt == 60) m_mode = M_PLAY;
                end
                M_PLAY: if (tick) begin
                    if (m_x <= 7) begin
                        m_sr = bump(m_sr); m_pr = 1; m_last_l = 0; m_mode = M_POINT;
                    end else if (m_x + 8 >= 632) begin
                        m_sl = bump(m_sl); m_pl = 1; m_last_l = 1; m_mode = M_POINT;
                    end else begin
                        odx = m_dx;
                        ody = m_dy;
                        hl = (m_x < 16) && overlap(m_y, int'(paddle_l_y));
                        hr = !hl && (m_x + 8 > 623) && overlap(m_y, int'(paddle_r_y));
                        if (hl || hr) begin
                            m_dirx = hr;
                            m_dy   = 2 * int'(rand_in[2:1]) + 1;
`ifdef SPEED_RAMP_EN
                            m_dx   = (m_dx + 1 > 6) ? 6 : m_dx + 1;
`endif
                            reroll();
                        end
                        if (m_y < 8) m_diry = 0;
                        else if (m_y + 8 > 471) m_diry = 1;
                        if (m_dirx) m_x = (m_x - odx < 0) ? 0 : m_x - odx;
                        else        m_x = (m_x + odx > 632) ? 632 : m_x + odx;
                        if (m_diry) m_y = (m_y - ody < 0) ? 0 : m_y - ody;
                        else        m_y = (m_y + ody > 472) ? 472 : m_y + ody;
                    end
                end
                M_POINT: begin
                    if ((m_last_l ? m_sl : m_sr) == 11) m_mode = M_OVER;
                    else serve(!m_last_l);
                end
                M_OVER: if (start) begin
                    m_mode = M_IDLE; m_sl = 0; m_sr = 0;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        logic [63:0] act, exp;
        @(negedge clk);
        if (m_valid) begin
            act = {24'd0, ball_x, ball_y, dir_x, score_l, score_r,
                   point_l, point_r, in_play, game_over};
            exp = {24'd0, 10'(m_x), 9'(m_y), m_dirx, 8'(to_bcd(m_sl)), 8'(to_bcd(m_sr)),
                   m_pl, m_pr, (m_mode == M_PLAY), (m_mode == M_OVER)};
            check("cycle", act, exp);
        end
    end

    function automatic int pad_pos(input bit trk);
        int v;
        if (trk) begin
            v = m_y - int'($urandom_range(0, 60));
            if (v < 0) v = 0;
        end else begin
            v = int'($urandom_range(0, 416));
        end
        return v;
    endfunction

    task automatic drive(input bit t, input bit s, input bit r);
        tick       = t;
        start      = s;
        reset      = r;
        rand_in    = 16'($urandom);
        paddle_l_y = 9'(pad_pos(trk_l && !no_track));
        paddle_r_y = 9'(pad_pos(trk_r && !no_track));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  cyc;
        bit  found;
        drive(0, 0, 1);
        drive(0, 0, 1);
        check("rst_x", ball_x, 64'd316);
        check("rst_y", ball_y, 64'd236);
        check("rst_score", {score_l, score_r}, 64'h0);
        check("rst_flags", {dir_x, point_l, point_r, in_play, game_over}, 64'h0);

        drive(0, 1, 0);
        check("serve_entry", in_play, 64'd0);
        repeat (59) drive(1, 0, 0);
        check("serve_hold", in_play, 64'd0);
        drive(1, 0, 0);
        check("serve_done", in_play, 64'd1);
        check("serve_pos", {ball_x, ball_y}, {45'd0, 10'd316, 9'd236});
        drive(1, 0, 0);
        check("first_move", ball_x, 64'd318);
        check("first_dir", dir_x, 64'd0);

        cyc = 0;
        while (m_mode != M_OVER && cyc < 60000) begin
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0), 0);
            cyc++;
        end
        check("game_over", game_over, 64'd1);
        check("winner_score", ((score_l == 8'h11) || (score_r == 8'h11)), 64'd1);

        repeat (100) drive(1, 0, 0);
        check("over_hold", {game_over, in_play}, 64'b10);
        drive(0, 1, 0);
        check("clear_scores", {score_l, score_r}, 64'h0);
        check("back_idle", game_over, 64'd0);

        no_track = 1;
        drive(0, 1, 0);
        found = 0;
        cyc = 0;
        while (!found && cyc < 20000) begin
            if (m_mode == M_PLAY && (m_x <= 7 || m_x >= 624))
                found = 1;
            else begin
                drive(1, 0, 0);
                cyc++;
            end
        end
        check("goal_reached", found, 64'd1);
        drive(1, 0, 1);
        check("rst_no_pulse", {point_l, point_r}, 64'h0);
        check("rst_mid_play", {ball_x, ball_y, in_play, game_over}, {43'd0, 10'd316, 9'd236, 2'b00});
        drive(0, 0, 0);
        check("rst_hold", {point_l, point_r, in_play, score_l, score_r}, 64'h0);
        drive(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
